// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based RAW hazard control for an in-order pipeline with STAGES tracked stages after ID.
// Define PIPE_HAZARD_FWD_EN for forwarding (load-use stall only); otherwise full interlock.
module pipe_hazard_ctrl #(
   parameter int STAGES = 3,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [RA_W-1:0]   id_src1,
   input  logic [RA_W-1:0]   id_src2,
   input  logic              id_src1_en,
   input  logic              id_src2_en,
   input  logic [RA_W-1:0]   id_dest,
   input  logic              id_gr_we,
   input  logic              id_is_load,
   input  logic [STAGES-1:0] stage_ready_go,
   input  logic              out_allowin,
   output logic              id_ready_go,
   output logic              id_allowin,
   output logic [STAGES-1:0] stage_valid,
   output logic [STAGES-1:0] stage_allowin,
   output logic [STAGES:0]   fwd_sel1,
   output logic [STAGES:0]   fwd_sel2,
   output logic [31:0]       hazard_cnt
);

   logic [STAGES-1:0] valid_reg;
   logic [RA_W-1:0]   dest_reg [STAGES];
   logic [STAGES-1:0] we_reg;
   logic [STAGES-1:0] load_reg;
   logic [STAGES-1:0] allowin;
   logic [STAGES-1:0] match1;
   logic [STAGES-1:0] match2;
   logic              issue;
   logic [31:0]       hazard_cnt_reg;
   logic              unused_load;

   // Backpressure ripples from the sink toward stage 0.
   always_comb begin
      logic nxt;
      nxt = out_allowin;
      allowin = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         allowin[k] = !valid_reg[k] | (stage_ready_go[k] & nxt);
         nxt = allowin[k];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_match
         assign match1[gi] = id_src1_en & valid_reg[gi] & we_reg[gi]
                             & (dest_reg[gi] == id_src1) & (id_src1 != '0);
         assign match2[gi] = id_src2_en & valid_reg[gi] & we_reg[gi]
                             & (dest_reg[gi] == id_src2) & (id_src2 != '0);
      end
   endgenerate

`ifdef PIPE_HAZARD_FWD_EN
   // Scan oldest to youngest so the youngest matching stage overrides.
   always_comb begin
      fwd_sel1 = '0;
      fwd_sel1[0] = 1'b1;
      fwd_sel2 = '0;
      fwd_sel2[0] = 1'b1;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (match1[k]) begin
            fwd_sel1 = '0;
            fwd_sel1[k+1] = 1'b1;
         end
         if (match2[k]) begin
            fwd_sel2 = '0;
            fwd_sel2[k+1] = 1'b1;
         end
      end
   end

   assign id_ready_go = !(load_reg[0] & (match1[0] | match2[0]));
`else
   assign fwd_sel1 = {{STAGES{1'b0}}, 1'b1};
   assign fwd_sel2 = {{STAGES{1'b0}}, 1'b1};
   assign id_ready_go = !((|match1) | (|match2));
`endif

   // Only the stage-0 load flag feeds hazard logic; the rest just travel with the entry.
   assign unused_load = ^load_reg;

   assign issue      = id_valid & id_ready_go & allowin[0];
   assign id_allowin = !id_valid | (id_ready_go & allowin[0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= '0;
      end else begin
         if (allowin[0]) valid_reg[0] <= issue;
         for (int k = 1; k < STAGES; k++) begin
            if (allowin[k]) valid_reg[k] <= valid_reg[k-1] & stage_ready_go[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (allowin[0]) begin
         dest_reg[0] <= id_dest;
         we_reg[0]   <= id_gr_we;
         load_reg[0] <= id_is_load;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (allowin[k]) begin
            dest_reg[k] <= dest_reg[k-1];
            we_reg[k]   <= we_reg[k-1];
            load_reg[k] <= load_reg[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hazard_cnt_reg <= '0;
      end else if (id_valid && !id_ready_go && (hazard_cnt_reg != 32'hFFFF_FFFF)) begin
         hazard_cnt_reg <= hazard_cnt_reg + 32'd1;
      end
   end

   assign stage_valid   = valid_reg;
   assign stage_allowin = allowin;
   assign hazard_cnt    = hazard_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues expected values, a negedge monitor compares.
// Expectations follow the PIPE_HAZARD_FWD_EN build selection.
module tb_pipe_hazard_ctrl;
   localparam int STAGES = 3;
   localparam int RA_W   = 5;

   localparam int S_RDY = 0;
   localparam int S_ALW = 1;
   localparam int S_F1  = 2;
   localparam int S_F2  = 3;
   localparam int S_SV  = 4;
   localparam int S_SA  = 5;
   localparam int S_CNT = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid;
   logic [RA_W-1:0]   id_src1;
   logic [RA_W-1:0]   id_src2;
   logic              id_src1_en;
   logic              id_src2_en;
   logic [RA_W-1:0]   id_dest;
   logic              id_gr_we;
   logic              id_is_load;
   logic [STAGES-1:0] stage_ready_go;
   logic              out_allowin;
   logic              id_ready_go;
   logic              id_allowin;
   logic [STAGES-1:0] stage_valid;
   logic [STAGES-1:0] stage_allowin;
   logic [STAGES:0]   fwd_sel1;
   logic [STAGES:0]   fwd_sel2;
   logic [31:0]       hazard_cnt;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] value;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   pipe_hazard_ctrl #(.STAGES(STAGES), .RA_W(RA_W)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
      .id_dest(id_dest), .id_gr_we(id_gr_we), .id_is_load(id_is_load),
      .stage_ready_go(stage_ready_go), .out_allowin(out_allowin),
      .id_ready_go(id_ready_go), .id_allowin(id_allowin),
      .stage_valid(stage_valid), .stage_allowin(stage_allowin),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .hazard_cnt(hazard_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_RDY:   return {31'b0, id_ready_go};
         S_ALW:   return {31'b0, id_allowin};
         S_F1:    return 32'(fwd_sel1);
         S_F2:    return 32'(fwd_sel2);
         S_SV:    return 32'(stage_valid);
         S_SA:    return 32'(stage_allowin);
         S_CNT:   return hazard_cnt;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: every negedge, drain whatever the stimulus queued for this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (actual(e.sig) !== e.value) begin
               errors++;
               $display("FAIL %s: got %h want %h (t=%0t)", e.name, actual(e.sig), e.value, $time);
            end else begin
               $display("ok   %s = %h (t=%0t)", e.name, e.value, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timed out");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string name, input int sig, input logic [31:0] v);
      exp_t e;
      e.name  = name;
      e.sig   = sig;
      e.value = v;
      sb_q.push_back(e);
   endtask

   task automatic idle_inputs();
      id_valid       = 1'b0;
      id_src1        = '0;
      id_src2        = '0;
      id_src1_en     = 1'b0;
      id_src2_en     = 1'b0;
      id_dest        = '0;
      id_gr_we       = 1'b0;
      id_is_load     = 1'b0;
      stage_ready_go = '1;
      out_allowin    = 1'b1;
   endtask

   task automatic issue_op(input logic [RA_W-1:0] dest, input logic we, input logic ld);
      id_valid   = 1'b1;
      id_dest    = dest;
      id_gr_we   = we;
      id_is_load = ld;
      id_src1_en = 1'b0;
      id_src2_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      expect_v("rst_stage_valid", S_SV, 32'h0);
      expect_v("rst_hazard_cnt", S_CNT, 32'h0);
      expect_v("rst_ready_go", S_RDY, 32'h1);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();

      // add r4, then add reading r4
      do_reset();
      issue_op(5'd4, 1'b1, 1'b0);
      expect_v("s1_first_ready", S_RDY, 32'h1);
      expect_v("s1_first_allowin", S_ALW, 32'h1);
      tick();
      issue_op(5'd7, 1'b1, 1'b0);
      id_src1 = 5'd4; id_src1_en = 1'b1;
`ifdef PIPE_HAZARD_FWD_EN
      expect_v("s1_ready", S_RDY, 32'h1);
      expect_v("s1_fwd_sel1", S_F1, 32'b0010);
      tick();
      idle_inputs();
      expect_v("s1_stage_valid", S_SV, 32'b011);
      expect_v("s1_hazard_cnt", S_CNT, 32'h0);
      tick();
`else
      expect_v("s1_stall0_ready", S_RDY, 32'h0);
      expect_v("s1_stall0_fwd1", S_F1, 32'b0001);
      expect_v("s1_stall0_sv", S_SV, 32'b001);
      expect_v("s1_stall0_allowin", S_ALW, 32'h0);
      tick();
      expect_v("s1_stall1_ready", S_RDY, 32'h0);
      expect_v("s1_stall1_sv", S_SV, 32'b010);
      tick();
      expect_v("s1_stall2_ready", S_RDY, 32'h0);
      expect_v("s1_stall2_sv", S_SV, 32'b100);
      tick();
      expect_v("s1_go_ready", S_RDY, 32'h1);
      expect_v("s1_hazard_cnt", S_CNT, 32'd3);
      expect_v("s1_go_sv", S_SV, 32'b000);
      tick();
      idle_inputs();
      expect_v("s1_issued_sv", S_SV, 32'b001);
      tick();
`endif

      // ld r5, then add reading r5 on src2
      do_reset();
      issue_op(5'd5, 1'b1, 1'b1);
      tick();
      issue_op(5'd8, 1'b1, 1'b0);
      id_src2 = 5'd5; id_src2_en = 1'b1;
      expect_v("s2_loaduse_ready", S_RDY, 32'h0);
`ifdef PIPE_HAZARD_FWD_EN
      expect_v("s2_stall_fwd2", S_F2, 32'b0010);
      tick();
      expect_v("s2_after_ready", S_RDY, 32'h1);
      expect_v("s2_after_fwd2", S_F2, 32'b0100);
      expect_v("s2_hazard_cnt", S_CNT, 32'd1);
`else
      expect_v("s2_stall_fwd2", S_F2, 32'b0001);
      tick();
      expect_v("s2_after_ready", S_RDY, 32'h0);
      expect_v("s2_after_fwd2", S_F2, 32'b0001);
      expect_v("s2_hazard_cnt", S_CNT, 32'd1);
`endif
      tick();

      // r0 destination never matches
      do_reset();
      issue_op(5'd0, 1'b1, 1'b0);
      tick();
      issue_op(5'd9, 1'b1, 1'b0);
      id_src1 = 5'd0; id_src1_en = 1'b1;
      expect_v("s3_r0_ready", S_RDY, 32'h1);
      expect_v("s3_r0_fwd1", S_F1, 32'b0001);
      expect_v("s3_r0_sv", S_SV, 32'b001);
      tick();

      // r6 in stages 0 and 2, r9 in stage 1
      do_reset();
      issue_op(5'd6, 1'b1, 1'b0);
      tick();
      issue_op(5'd9, 1'b1, 1'b0);
      tick();
      issue_op(5'd6, 1'b1, 1'b0);
      tick();
      issue_op(5'd11, 1'b1, 1'b0);
      id_src1 = 5'd6; id_src1_en = 1'b1;
      id_src2 = 5'd9; id_src2_en = 1'b1;
      expect_v("s4_sv_full", S_SV, 32'b111);
`ifdef PIPE_HAZARD_FWD_EN
      expect_v("s4_ready", S_RDY, 32'h1);
      expect_v("s4_youngest_fwd1", S_F1, 32'b0010);
      expect_v("s4_mid_fwd2", S_F2, 32'b0100);
`else
      expect_v("s4_ready", S_RDY, 32'h0);
      expect_v("s4_fwd1", S_F1, 32'b0001);
      expect_v("s4_fwd2", S_F2, 32'b0001);
`endif
      tick();

      // stage 1 not ready: hold 0..1, bubble into 2
      do_reset();
      issue_op(5'd1, 1'b1, 1'b0); tick();
      issue_op(5'd2, 1'b1, 1'b0); tick();
      issue_op(5'd3, 1'b1, 1'b0); tick();
      issue_op(5'd13, 1'b1, 1'b0);
      stage_ready_go = 3'b101;
      expect_v("s5_sa", S_SA, 32'b100);
      expect_v("s5_sv", S_SV, 32'b111);
      expect_v("s5_id_allowin", S_ALW, 32'h0);
      tick();
      expect_v("s5_bubble_sv", S_SV, 32'b011);
      expect_v("s5_bubble_sa", S_SA, 32'b100);
      tick();
      stage_ready_go = 3'b111;
      expect_v("s5_resume_sa", S_SA, 32'b111);
      expect_v("s5_resume_alw", S_ALW, 32'h1);
      tick();

      // sink blocked with every stage full
      do_reset();
      issue_op(5'd1, 1'b1, 1'b0); tick();
      issue_op(5'd2, 1'b1, 1'b0); tick();
      issue_op(5'd3, 1'b1, 1'b0); tick();
      out_allowin = 1'b0;
      issue_op(5'd10, 1'b1, 1'b0);
      id_src1 = 5'd1; id_src1_en = 1'b1;
      id_src2 = 5'd3; id_src2_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         expect_v("s6_sa", S_SA, 32'b000);
         expect_v("s6_sv", S_SV, 32'b111);
         expect_v("s6_id_allowin", S_ALW, 32'h0);
`ifdef PIPE_HAZARD_FWD_EN
         expect_v("s6_fwd1_oldest", S_F1, 32'b1000);
         expect_v("s6_fwd2_youngest", S_F2, 32'b0010);
`else
         expect_v("s6_ready", S_RDY, 32'h0);
`endif
         tick();
      end
      out_allowin = 1'b1;
      expect_v("s6_release_sa", S_SA, 32'b111);
`ifdef PIPE_HAZARD_FWD_EN
      expect_v("s6_hazard_cnt", S_CNT, 32'd0);
      expect_v("s6_release_alw", S_ALW, 32'h1);
`else
      expect_v("s6_hazard_cnt", S_CNT, 32'd5);
      expect_v("s6_release_alw", S_ALW, 32'h0);
`endif
      tick();

      // counter saturation, then reset mid-stall
      do_reset();
      issue_op(5'd4, 1'b1, 1'b1);
      tick();
      stage_ready_go = 3'b110;
      issue_op(5'd12, 1'b1, 1'b0);
      id_src1 = 5'd4; id_src1_en = 1'b1;
      force dut.hazard_cnt_reg = 32'hFFFF_FFFE;
      #1;
      release dut.hazard_cnt_reg;
      expect_v("s7_stall_ready", S_RDY, 32'h0);
      expect_v("s7_preset_cnt", S_CNT, 32'hFFFF_FFFE);
      tick();
      expect_v("s7_cnt_max", S_CNT, 32'hFFFF_FFFF);
      tick();
      expect_v("s7_cnt_sat1", S_CNT, 32'hFFFF_FFFF);
      tick();
      expect_v("s7_cnt_sat2", S_CNT, 32'hFFFF_FFFF);
      expect_v("s7_still_stalled", S_RDY, 32'h0);
      tick();
      reset = 1'b1;
      expect_v("s7_rst_cnt", S_CNT, 32'h0);
      expect_v("s7_rst_sv", S_SV, 32'b000);
      tick();
      reset = 1'b0;
      expect_v("s7_post_rst_ready", S_RDY, 32'h1);
      expect_v("s7_post_rst_fwd1", S_F1, 32'b0001);
      tick();

      idle_inputs();
      tick();
      tick();
      if (sb_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
